// File: rtl/lsu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : RV64I load/store unit controller. Accepts one request at a
//               time, checks it for faults, performs a single-cycle access
//               to a byte-addressed data memory and returns an extended
//               load result (or fault cause) through a valid/ready response.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  // request channel
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [4:0]  req_rd,
  // data memory
  output logic        mem_rden,
  output logic [7:0]  mem_wren,
  output logic [31:0] mem_rdaddress,
  output logic [31:0] mem_wraddress,
  output logic [63:0] mem_write_data,
  input  logic [63:0] mem_read_data,
  // response channel
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic [1:0]  resp_cause
);

  // FSM encoding
  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_access = 2'd1;
  localparam logic [1:0] c_st_resp   = 2'd2;

  // Response cause codes
  localparam logic [1:0] c_cause_ok        = 2'b00;
  localparam logic [1:0] c_cause_misalign  = 2'b01;
  localparam logic [1:0] c_cause_illegal   = 2'b10;
  localparam logic [1:0] c_cause_range     = 2'b11;

  // Memory size widened by one bit so addr+size-1 never wraps
  localparam logic [32:0] c_mem_bytes = 33'(MEM_BYTES);

  // --------------------------------------------------------------------------
  // State and latched request fields
  // --------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;

  // Registered memory-side outputs
  logic        r_mem_rden;
  logic [7:0]  r_mem_wren;
  logic [31:0] r_mem_rdaddress;
  logic [31:0] r_mem_wraddress;
  logic [63:0] r_mem_write_data;

  // Registered response-side outputs
  logic        r_resp_valid;
  logic [63:0] r_resp_data;
  logic [4:0]  r_resp_rd;
  logic [1:0]  r_resp_cause;

  // Request decode results
  logic [2:0]  w_size_m1;
  logic [7:0]  w_wmask;
  logic        w_illegal;
  logic        w_misaligned;
  logic [32:0] w_last_byte;
  logic        w_out_of_range;
  logic [1:0]  w_cause;

  // Extended load result from the current memory word
  logic [63:0] w_load_ext;

  // --------------------------------------------------------------------------
  // Decode the incoming request: access size, byte mask and fault cause.
  // Faults are prioritised illegal > misaligned > out of range.
  // --------------------------------------------------------------------------
  always_comb begin
    w_size_m1 = 3'd0;
    w_wmask   = 8'h01;
    case (req_funct3[1:0])
      2'b00: begin w_size_m1 = 3'd0; w_wmask = 8'h01; end
      2'b01: begin w_size_m1 = 3'd1; w_wmask = 8'h03; end
      2'b10: begin w_size_m1 = 3'd3; w_wmask = 8'h0F; end
      default: begin w_size_m1 = 3'd7; w_wmask = 8'hFF; end
    endcase

    // Stores only have four encodings; loads reserve 111
    w_illegal      = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
    // Natural alignment: the low address bits covered by the size must be 0
    w_misaligned   = |(req_addr[2:0] & w_size_m1);
    w_last_byte    = {1'b0, req_addr} + {30'd0, w_size_m1};
    w_out_of_range = (w_last_byte >= c_mem_bytes);

    if (w_illegal) begin
      w_cause = c_cause_illegal;
    end else if (w_misaligned) begin
      w_cause = c_cause_misalign;
    end else if (w_out_of_range) begin
      w_cause = c_cause_range;
    end else begin
      w_cause = c_cause_ok;
    end
  end

  // --------------------------------------------------------------------------
  // Size/sign extension of the memory word. The memory returns bytes starting
  // at the requested address, so the operand is always the low bits.
  // --------------------------------------------------------------------------
  always_comb begin
    w_load_ext = mem_read_data;
    case (r_funct3)
      3'b000:  w_load_ext = {{56{mem_read_data[7]}},  mem_read_data[7:0]};
      3'b001:  w_load_ext = {{48{mem_read_data[15]}}, mem_read_data[15:0]};
      3'b010:  w_load_ext = {{32{mem_read_data[31]}}, mem_read_data[31:0]};
      3'b100:  w_load_ext = {56'd0, mem_read_data[7:0]};
      3'b101:  w_load_ext = {48'd0, mem_read_data[15:0]};
      3'b110:  w_load_ext = {32'd0, mem_read_data[31:0]};
      default: w_load_ext = mem_read_data;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request/access/response sequencing. Memory strobes are raised on the
  // accept edge and dropped on the following edge, so they are high for
  // exactly the ACCESS cycle; asynchronous reset kills them immediately.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= c_st_idle;
      r_we             <= 1'b0;
      r_funct3         <= 3'd0;
      r_rd             <= 5'd0;
      r_mem_rden       <= 1'b0;
      r_mem_wren       <= 8'h00;
      r_mem_rdaddress  <= 32'd0;
      r_mem_wraddress  <= 32'd0;
      r_mem_write_data <= 64'd0;
      r_resp_valid     <= 1'b0;
      r_resp_data      <= 64'd0;
      r_resp_rd        <= 5'd0;
      r_resp_cause     <= c_cause_ok;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_rd     <= req_rd;
            if (w_cause != c_cause_ok) begin
              // Faulting request: answer straight away, memory untouched
              r_state      <= c_st_resp;
              r_resp_valid <= 1'b1;
              r_resp_data  <= 64'd0;
              r_resp_rd    <= req_rd;
              r_resp_cause <= w_cause;
            end else begin
              r_state <= c_st_access;
              if (req_we) begin
                r_mem_wren       <= w_wmask;
                r_mem_wraddress  <= req_addr;
                r_mem_write_data <= req_wdata;
              end else begin
                r_mem_rden      <= 1'b1;
                r_mem_rdaddress <= req_addr;
              end
            end
          end
        end

        c_st_access: begin
          // Single access cycle; read data is captured on this edge
          r_mem_rden   <= 1'b0;
          r_mem_wren   <= 8'h00;
          r_state      <= c_st_resp;
          r_resp_valid <= 1'b1;
          r_resp_data  <= r_we ? 64'd0 : w_load_ext;
          r_resp_rd    <= r_rd;
          r_resp_cause <= c_cause_ok;
        end

        c_st_resp: begin
          // Response fields hold until the consumer takes them
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= c_st_idle;
          end
        end

        default: begin
          r_state      <= c_st_idle;
          r_mem_rden   <= 1'b0;
          r_mem_wren   <= 8'h00;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs come straight from registers
  // --------------------------------------------------------------------------
  assign req_ready      = (r_state == c_st_idle);
  assign mem_rden       = r_mem_rden;
  assign mem_wren       = r_mem_wren;
  assign mem_rdaddress  = r_mem_rdaddress;
  assign mem_wraddress  = r_mem_wraddress;
  assign mem_write_data = r_mem_write_data;
  assign resp_valid     = r_resp_valid;
  assign resp_data      = r_resp_data;
  assign resp_rd        = r_resp_rd;
  assign resp_cause     = r_resp_cause;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Self-checking bench for lsu_ctrl with a byte-array data
//               memory, a reference memory image and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

  localparam int unsigned MEM_BYTES = 65536;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [63:0] req_wdata = 64'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        mem_rden;
  logic [7:0]  mem_wren;
  logic [31:0] mem_rdaddress;
  logic [31:0] mem_wraddress;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] resp_data;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_cause;

  lsu_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_rd         (req_rd),
    .mem_rden       (mem_rden),
    .mem_wren       (mem_wren),
    .mem_rdaddress  (mem_rdaddress),
    .mem_wraddress  (mem_wraddress),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .resp_rd        (resp_rd),
    .resp_cause     (resp_cause)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard entry: {cause[70:69], data[68:5], rd[4:0]}
  logic [70:0] exp_q[$];

  logic [7:0] mem     [0:MEM_BYTES-1];
  logic [7:0] ref_mem [0:MEM_BYTES-1];
  bit         mem_init = 1'b0;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Data memory: combinational little-endian read, byte-masked write
  always_comb begin
    mem_read_data = '0;
    for (int i = 0; i < 8; i++)
      mem_read_data[8*i +: 8] = mem[int'((mem_rdaddress + 32'(i)) % MEM_BYTES)];
  end

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] <= pat(i);
      mem_init <= 1'b1;
    end else begin
      for (int i = 0; i < 8; i++)
        if (mem_wren[i])
          mem[int'((mem_wraddress + 32'(i)) % MEM_BYTES)] <= mem_write_data[8*i +: 8];
    end
  end

  // Reference load result from the bench's own memory image
  function automatic logic [63:0] load_model(input logic [2:0] f3, input logic [31:0] a);
    logic [63:0]       w;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] sw;
    longint            idx;
    longint            r;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      idx = longint'(a) + i;
      w[8*i +: 8] = (idx < longint'(MEM_BYTES)) ? ref_mem[int'(idx)] : 8'h00;
    end
    sb = w[7:0];
    sh = w[15:0];
    sw = w[31:0];
    case (f3)
      3'b000:  r = longint'(sb);
      3'b001:  r = longint'(sh);
      3'b010:  r = longint'(sw);
      3'b011:  r = longint'(w);
      3'b100:  r = longint'(w[7:0]);
      3'b101:  r = longint'(w[15:0]);
      3'b110:  r = longint'(w[31:0]);
      default: r = 0;
    endcase
    return 64'(r);
  endfunction

  // Work out the expected response, update the reference image, push it
  task automatic predict(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [63:0] wd, input logic [4:0] rd, output logic [1:0] cause);
    int          sz;
    logic [63:0] data;
    sz = 1 << f3[1:0];
    if (we ? f3[2] : (f3 == 3'b111))                        cause = 2'b10;
    else if ((addr % 32'(sz)) != 0)                          cause = 2'b01;
    else if (longint'(addr) + sz - 1 >= longint'(MEM_BYTES)) cause = 2'b11;
    else                                                     cause = 2'b00;
    data = '0;
    if (cause == 2'b00) begin
      if (we) begin
        for (int i = 0; i < sz; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        data = load_model(f3, addr);
      end
    end
    exp_q.push_back({cause, data, rd});
  endtask

  // Response monitor: compares every handshaken response with the scoreboard
  always @(negedge clk) begin : mon
    logic [70:0] e;
    if (rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_resp", 64'(resp_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_cause", 64'(resp_cause), 64'(e[70:69]));
        check("resp_data",  resp_data,       e[68:5]);
        check("resp_rd",    64'(resp_rd),    64'(e[4:0]));
      end
    end
  end

  // One full request: drive, check the access cycle, latency and drain
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [63:0] wd, input logic [4:0] rd);
    logic [1:0] cause;
    logic [7:0] exp_mask;
    int         n;
    int         lat;
    predict(we, f3, addr, wd, rd, cause);
    exp_mask = 8'((1 << (1 << f3[1:0])) - 1);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wd; req_rd = rd;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check("req_ready_wait", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    if (cause == 2'b00) begin
      check("acc_rden", 64'(mem_rden), 64'(!we));
      if (we) begin
        check("acc_wren",   64'(mem_wren),      64'(exp_mask));
        check("acc_wraddr", 64'(mem_wraddress), 64'(addr));
        check("acc_wdata",  mem_write_data,     wd);
      end else begin
        check("acc_wren_ld", 64'(mem_wren),      64'd0);
        check("acc_rdaddr",  64'(mem_rdaddress), 64'(addr));
      end
    end
    while (!resp_valid && lat < 8) begin @(negedge clk); lat++; end
    check("latency", 64'(lat), (cause == 2'b00) ? 64'd2 : 64'd1);
    check("resp_mem_idle", {55'd0, mem_rden, mem_wren}, 64'd0);
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      check("resp_drain", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [1:0]  cause;
    logic [70:0] e;
    for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = pat(i);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_mem_strobe", {55'd0, mem_rden, mem_wren}, 64'd0);
    check("rst_resp_data",  resp_data, 64'd0);
    check("rst_resp_meta",  {57'd0, resp_rd, resp_cause}, 64'd0);
    check("rst_mem_addr",   {mem_rdaddress, mem_wraddress}, 64'd0);
    check("rst_mem_wdata",  mem_write_data, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);

    // Store then loads of all sizes and signedness
    do_req(1'b1, 3'b011, 32'h10, 64'h1122334455667788, 5'd1);  // SD
    do_req(1'b0, 3'b000, 32'h13, 64'd0, 5'd2);                 // LB  -> 0x55
    do_req(1'b0, 3'b000, 32'h10, 64'd0, 5'd3);                 // LB  -> sign 0x88
    do_req(1'b0, 3'b100, 32'h10, 64'd0, 5'd4);                 // LBU -> 0x88
    do_req(1'b0, 3'b010, 32'h14, 64'd0, 5'd5);                 // LW  -> 0x11223344
    do_req(1'b1, 3'b001, 32'h18, 64'hFFFF_FFFF_FFFF_9ABC, 5'd6); // SH
    do_req(1'b0, 3'b001, 32'h18, 64'd0, 5'd7);                 // LH
    do_req(1'b0, 3'b101, 32'h18, 64'd0, 5'd8);                 // LHU
    do_req(1'b1, 3'b010, 32'h1C, 64'h1234_5678_8000_0001, 5'd9); // SW
    do_req(1'b0, 3'b010, 32'h1C, 64'd0, 5'd10);                // LW
    do_req(1'b0, 3'b110, 32'h1C, 64'd0, 5'd11);                // LWU
    do_req(1'b1, 3'b000, 32'h1B, 64'h0000_0000_0000_00A5, 5'd12); // SB
    do_req(1'b0, 3'b011, 32'h18, 64'd0, 5'd13);                // LD

    // Faults and range boundaries
    do_req(1'b0, 3'b010, 32'h12, 64'd0, 5'd14);                // LW misaligned
    do_req(1'b1, 3'b001, 32'h11, 64'hFFFF, 5'd15);             // SH misaligned
    do_req(1'b0, 3'b111, 32'h13, 64'd0, 5'd16);                // illegal load
    do_req(1'b1, 3'b100, 32'h20, 64'd1, 5'd17);                // illegal store
    do_req(1'b0, 3'b000, 32'h0001_0000, 64'd0, 5'd18);         // LB out of range
    do_req(1'b1, 3'b011, 32'h0001_0000, 64'd5, 5'd19);         // SD out of range
    do_req(1'b0, 3'b011, 32'hFFFF_FFF8, 64'd0, 5'd20);         // LD, sum wraps 32 bits
    do_req(1'b0, 3'b011, 32'h0000_FFF8, 64'd0, 5'd22);         // LD last doubleword
    do_req(1'b0, 3'b000, 32'h0000_FFFF, 64'd0, 5'd23);         // LB last byte
    do_req(1'b0, 3'b001, 32'h0000_FFFF, 64'd0, 5'd24);         // LH misaligned at end

    // Back-pressure: response held while resp_ready is low
    predict(1'b0, 3'b011, 32'h10, 64'd0, 5'd21, cause);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 32'h10; req_rd = 5'd21;
    @(posedge clk); #1;
    req_funct3 = 3'b000; req_addr = 32'h13; req_rd = 5'd9;    // ignored request
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      e = (exp_q.size() != 0) ? exp_q[0] : '0;
      check("stall_valid",     64'(resp_valid), 64'd1);
      check("stall_data",      resp_data,       e[68:5]);
      check("stall_rd",        64'(resp_rd),    64'(e[4:0]));
      check("stall_req_ready", 64'(req_ready),  64'd0);
      check("stall_rden",      64'(mem_rden),   64'd0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_idle_ready", 64'(req_ready),   64'd1);
    check("stall_idle_valid", 64'(resp_valid),  64'd0);
    check("stall_q_empty",    64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // Reset during the ACCESS cycle of a store
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h20; req_wdata = 64'hDEAD_BEEF_CAFE_F00D; req_rd = 5'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rsta_wren", 64'(mem_wren), 64'h0F);
    rst = 1'b0;
    #1;
    check("rsta_wren_clr",   64'(mem_wren),      64'd0);
    check("rsta_resp_valid", 64'(resp_valid),    64'd0);
    check("rsta_wraddr",     64'(mem_wraddress), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rsta_req_ready", 64'(req_ready), 64'd1);
    do_req(1'b0, 3'b010, 32'h20, 64'd0, 5'd8);                 // old contents

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
